vm_change_dispenser: RTL and testbench

//  Downstream of the payment stage. Accepts a change amount in cents with a one-cycle

---
 rtl/vm_change_dispenser.sv | 122 ++++++++++++
 tb/tb_vm_change_dispenser.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vm_change_dispenser.sv
// Greedy coin change dispenser: pays a cents amount largest-coin-first from
// per-denomination stock, one coin per valid/ack handshake with the hopper.
module vm_change_dispenser #(
  parameter int AMT_W      = 12,
  parameter int CNT_W      = 8,
  parameter int INIT_COUNT = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AMT_W-1:0] change_in,
  input  logic             change_valid,
  input  logic             refill,
  input  logic             coin_ack,
  output logic             coin_valid,
  output logic [4:0]       coin_sel,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AMT_W-1:0] short_amount,
  output logic             low_stock
);

  typedef enum logic [1:0] {IDLE, SELECT, OFFER, DONE} state_t;

  localparam int                NUM_DEN = 5;
  localparam logic [CNT_W-1:0]  FULL    = CNT_W'(INIT_COUNT);

  // Index 0..4 = nickel, dime, quarter, half, dollar (matches coin_sel bit order)
  function automatic logic [AMT_W-1:0] denom(input int i);
    case (i)
      4:       denom = AMT_W'(100);
      3:       denom = AMT_W'(50);
      2:       denom = AMT_W'(25);
      1:       denom = AMT_W'(10);
      default: denom = AMT_W'(5);
    endcase
  endfunction

  state_t                          state;
  logic [AMT_W-1:0]                remaining;
  logic [NUM_DEN-1:0][CNT_W-1:0]   stock;
  logic [2:0]                      cur_idx;
  logic [2:0]                      pick_idx;
  logic                            pick_ok;

  // Ascending scan so the largest qualifying denomination wins
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NUM_DEN; i++) begin
      if (denom(i) <= remaining && stock[i] != '0) begin
        pick_ok  = 1'b1;
        pick_idx = 3'(i);
      end
    end
  end

  always_comb begin
    low_stock = 1'b0;
    for (int i = 0; i < NUM_DEN; i++)
      if (stock[i] == '0) low_stock = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      remaining    <= '0;
      stock        <= {NUM_DEN{FULL}};
      cur_idx      <= '0;
      coin_valid   <= 1'b0;
      coin_sel     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      short_amount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (refill) stock <= {NUM_DEN{FULL}};
          if (change_valid) begin
            remaining    <= change_in;
            error        <= 1'b0;
            short_amount <= '0;
            busy         <= 1'b1;
            state        <= SELECT;
          end
        end
        SELECT: begin
          if (pick_ok) begin
            cur_idx    <= pick_idx;
            coin_sel   <= 5'(1) << pick_idx;
            coin_valid <= 1'b1;
            state      <= OFFER;
          end else begin
            // Nothing fits: either fully paid or a shortfall to report
            if (remaining != '0) begin
              error        <= 1'b1;
              short_amount <= remaining;
            end
            done  <= 1'b1;
            state <= DONE;
          end
        end
        OFFER: begin
          if (coin_ack) begin
            remaining       <= remaining - denom(int'(cur_idx));
            stock[cur_idx]  <= stock[cur_idx] - CNT_W'(1);
            coin_valid      <= 1'b0;
            coin_sel        <= '0;
            state           <= SELECT;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed-vector bench for vm_change_dispenser; a second instance with a
// stock of one coin per denomination covers the shortfall/low-stock path.
module tb_vm_change_dispenser;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] change_in;
  logic        change_valid, refill, coin_ack;
  logic        coin_valid, busy, done, error, low_stock;
  logic [4:0]  coin_sel;
  logic [11:0] short_amount;

  logic [11:0] lo_change_in;
  logic        lo_change_valid, lo_refill, lo_coin_ack;
  logic        lo_coin_valid, lo_busy, lo_done, lo_error, lo_low_stock;
  logic [4:0]  lo_coin_sel;
  logic [11:0] lo_short_amount;

  int n_vec = 0;
  int n_err = 0;
  logic [4:0] coins[$];

  always #5 clk = ~clk;

  vm_change_dispenser #(.AMT_W(12), .CNT_W(8), .INIT_COUNT(20)) dut (
    .clk(clk), .reset(reset), .change_in(change_in), .change_valid(change_valid),
    .refill(refill), .coin_ack(coin_ack), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .busy(busy), .done(done), .error(error), .short_amount(short_amount),
    .low_stock(low_stock));

  vm_change_dispenser #(.AMT_W(12), .CNT_W(8), .INIT_COUNT(1)) dut_lo (
    .clk(clk), .reset(reset), .change_in(lo_change_in), .change_valid(lo_change_valid),
    .refill(lo_refill), .coin_ack(lo_coin_ack), .coin_valid(lo_coin_valid),
    .coin_sel(lo_coin_sel), .busy(lo_busy), .done(lo_done), .error(lo_error),
    .short_amount(lo_short_amount), .low_stock(lo_low_stock));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] coin_at(input int i);
    return (i < coins.size()) ? coins[i] : 5'h1f;
  endfunction

  // Issue a request on dut, collect accepted coins, return cycle of done (0 = timeout)
  task automatic run_req(input logic [11:0] amt, output int done_cyc);
    coins.delete();
    done_cyc     = 0;
    change_in    = amt;
    change_valid = 1'b1;
    @(posedge clk); #1;
    change_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (coin_valid && coin_ack) coins.push_back(coin_sel);
      if (done) begin done_cyc = c; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_offer(input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (coin_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!seen) chk(tag, 0, 1);
  endtask

  initial begin
    int   dc;
    bit   stable;
    logic [4:0] sel0;

    reset = 1'b0; change_in = '0; change_valid = 1'b0; refill = 1'b0; coin_ack = 1'b1;
    lo_change_in = '0; lo_change_valid = 1'b0; lo_refill = 1'b0; lo_coin_ack = 1'b1;
    #12;
    chk("rst_coin_valid", coin_valid, 0);
    chk("rst_coin_sel", coin_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_short", short_amount, 0);
    chk("rst_low_stock", low_stock, 0);
    chk("rst_stock_dollar", dut.stock[4], 20);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: 65 cents -> half, dime, nickel
    run_req(12'd65, dc);
    chk("t1_done_cycle", dc, 8);
    chk("t1_ncoins", coins.size(), 3);
    chk("t1_coin0_half", coin_at(0), 5'b01000);
    chk("t1_coin1_dime", coin_at(1), 5'b00010);
    chk("t1_coin2_nickel", coin_at(2), 5'b00001);
    chk("t1_error", error, 0);
    chk("t1_short", short_amount, 0);
    chk("t1_stock_half", dut.stock[3], 19);
    chk("t1_stock_dime", dut.stock[1], 19);
    chk("t1_stock_nickel", dut.stock[0], 19);
    chk("t1_stock_dollar", dut.stock[4], 20);
    @(posedge clk); #1;
    chk("t1_idle_busy", busy, 0);
    chk("t1_done_pulse", done, 0);

    // 2: zero change
    run_req(12'd0, dc);
    chk("t2_done_cycle", dc, 2);
    chk("t2_ncoins", coins.size(), 0);
    chk("t2_error", error, 0);
    @(posedge clk); #1;

    // 3: 3 cents cannot be paid
    run_req(12'd3, dc);
    chk("t3_done_cycle", dc, 2);
    chk("t3_ncoins", coins.size(), 0);
    chk("t3_error", error, 1);
    chk("t3_short", short_amount, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t3_error_hold", error, 1);
    chk("t3_short_hold", short_amount, 3);

    // 4: one coin of each, 200 cents requested
    coins.delete();
    dc = 0;
    lo_change_in = 12'd200; lo_change_valid = 1'b1;
    @(posedge clk); #1;
    lo_change_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (lo_coin_valid && lo_coin_ack) coins.push_back(lo_coin_sel);
      if (lo_done) begin dc = c; break; end
      @(posedge clk); #1;
    end
    chk("t4_done_seen", dc != 0, 1);
    chk("t4_ncoins", coins.size(), 5);
    chk("t4_coin0_dollar", coin_at(0), 5'b10000);
    chk("t4_coin1_half", coin_at(1), 5'b01000);
    chk("t4_coin2_quarter", coin_at(2), 5'b00100);
    chk("t4_coin3_dime", coin_at(3), 5'b00010);
    chk("t4_coin4_nickel", coin_at(4), 5'b00001);
    chk("t4_error", lo_error, 1);
    chk("t4_short", lo_short_amount, 10);
    chk("t4_low_stock", lo_low_stock, 1);
    @(posedge clk); #1;
    lo_refill = 1'b1;
    @(posedge clk); #1;
    lo_refill = 1'b0;
    chk("t4_refill_low_stock", lo_low_stock, 0);
    chk("t4_error_after_refill", lo_error, 1);

    // 5: hopper stalls 5 cycles; a second request while busy is dropped
    coin_ack = 1'b0;
    change_in = 12'd30; change_valid = 1'b1;
    @(posedge clk); #1;
    change_valid = 1'b0;
    chk("t5_error_cleared", error, 0);
    wait_offer("t5_offer_timeout");
    sel0 = coin_sel;
    chk("t5_first_quarter", sel0, 5'b00100);
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin change_in = 12'd100; change_valid = 1'b1; end
      @(posedge clk); #1;
      change_valid = 1'b0;
      if (!coin_valid || coin_sel !== sel0) stable = 1'b0;
    end
    chk("t5_stable", stable, 1);
    coin_ack = 1'b1;
    coins.delete();
    dc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (coin_valid && coin_ack) coins.push_back(coin_sel);
      if (done) begin dc = c; break; end
      @(posedge clk); #1;
    end
    chk("t5_done_seen", dc != 0, 1);
    chk("t5_ncoins", coins.size(), 2);
    chk("t5_coin1_nickel", coin_at(1), 5'b00001);
    chk("t5_error", error, 0);
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
    chk("t5_no_queued_req", busy, 0);
    chk("t5_stock_quarter", dut.stock[2], 19);
    chk("t5_stock_nickel", dut.stock[0], 18);
    chk("t5_stock_dollar", dut.stock[4], 20);

    // 6: reset in the middle of an offer
    coin_ack = 1'b0;
    change_in = 12'd100; change_valid = 1'b1;
    @(posedge clk); #1;
    change_valid = 1'b0;
    wait_offer("t6_offer_timeout");
    chk("t6_offer_dollar", coin_sel, 5'b10000);
    reset = 1'b0;
    #2;
    chk("t6_rst_coin_valid", coin_valid, 0);
    chk("t6_rst_coin_sel", coin_sel, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_stock_nickel", dut.stock[0], 20);
    chk("t6_rst_stock_half", dut.stock[3], 20);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    coin_ack = 1'b1;
    run_req(12'd40, dc);
    chk("t6_done_cycle", dc, 8);
    chk("t6_ncoins", coins.size(), 3);
    chk("t6_coin0_quarter", coin_at(0), 5'b00100);
    chk("t6_coin1_dime", coin_at(1), 5'b00010);
    chk("t6_coin2_nickel", coin_at(2), 5'b00001);
    chk("t6_error", error, 0);
    chk("t6_stock_quarter", dut.stock[2], 19);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
